// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline stage: control-word layout,
// ALU operation encodings and the default datapath width.
package id_ex_stage_pkg;

  localparam int XLEN_DEF = 32;
  localparam int CTRL_W   = 8;
  localparam int REG_W    = 5;

  // Bit positions inside the 8-bit control word, MSB first.
  localparam int CTRL_REG_WRITE  = 7;
  localparam int CTRL_MEM_READ   = 6;
  localparam int CTRL_MEM_WRITE  = 5;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_ALU_SRC    = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_ALU_OP_HI  = 1;
  localparam int CTRL_ALU_OP_LO  = 0;

  typedef enum logic [1:0] {
    ALU_OP_ADD    = 2'b00,
    ALU_OP_BRANCH = 2'b01,
    ALU_OP_RTYPE  = 2'b10,
    ALU_OP_ITYPE  = 2'b11
  } alu_op_e;

  // Same bit order as the flat control word, so a cast maps field-for-field.
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
  } ctrl_t;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs);
    return (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID forces a one-cycle stall unless EX is flushing anyway.
module hazard_detect
  import id_ex_stage_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             id_valid,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             flush,
  output logic             load_use,
  output logic             pc_write,
  output logic             if_id_write
);

  logic rs1_dep;
  logic rs2_dep;

  assign rs1_dep  = id_use_rs1 && reg_match(ex_rd, id_rs1);
  assign rs2_dep  = id_use_rs2 && reg_match(ex_rd, id_rs2);
  assign load_use = ex_valid && ex_mem_read && id_valid && (rs1_dep || rs2_dep);

  // A flush kills the dependent instruction, so there is nothing to hold.
  assign pc_write    = !(load_use && !flush);
  assign if_id_write = pc_write;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush handling,
// writeback-to-operand bypass and saturating stall/flush counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   IF_ID_pc,
  input  logic [XLEN-1:0]   IF_ID_rs1_data,
  input  logic [XLEN-1:0]   IF_ID_rs2_data,
  input  logic [XLEN-1:0]   IF_ID_imm,
  input  logic [4:0]        IF_ID_rs1,
  input  logic [4:0]        IF_ID_rs2,
  input  logic [4:0]        IF_ID_rd,
  input  logic              IF_ID_use_rs1,
  input  logic              IF_ID_use_rs2,
  input  logic              IF_ID_valid,
  input  logic [7:0]        IF_ID_ctrl,
  input  logic              MEM_WB_regWrite,
  input  logic [4:0]        MEM_WB_rd,
  input  logic [XLEN-1:0]   MEM_WB_data,
  input  logic              EX_flush,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic [XLEN-1:0]   ID_EX_rs1_data,
  output logic [XLEN-1:0]   ID_EX_rs2_data,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [4:0]        ID_EX_rs1,
  output logic [4:0]        ID_EX_rs2,
  output logic [4:0]        ID_EX_rd,
  output logic [7:0]        ID_EX_ctrl,
  output logic              ID_EX_valid,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  rs1_data;
    logic [XLEN-1:0]  rs2_data;
    logic [XLEN-1:0]  imm;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    ctrl_t            ctrl;
    logic             valid;
  } ex_reg_t;

  ex_reg_t          ex_q;
  ex_reg_t          ex_d;
  logic             load_use;
  logic             stall_event;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_rd       (ex_q.rd),
    .id_valid    (IF_ID_valid),
    .id_use_rs1  (IF_ID_use_rs1),
    .id_use_rs2  (IF_ID_use_rs2),
    .id_rs1      (IF_ID_rs1),
    .id_rs2      (IF_ID_rs2),
    .flush       (EX_flush),
    .load_use    (load_use),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  assign stall_event = load_use && !EX_flush;

  // NOTE: every field gets the bubble value before the conditional load, so
  // each path assigns everything and no latch can be inferred.
  always_comb begin
    ex_d = '0;
    if (!EX_flush && !load_use) begin
      ex_d.pc       = IF_ID_pc;
      ex_d.imm      = IF_ID_imm;
      ex_d.rs1      = IF_ID_rs1;
      ex_d.rs2      = IF_ID_rs2;
      ex_d.rd       = IF_ID_rd;
      ex_d.valid    = IF_ID_valid;
      ex_d.ctrl     = IF_ID_valid ? ctrl_t'(IF_ID_ctrl) : '0;
      // Register-file write happening this cycle is not yet visible in ID.
      ex_d.rs1_data = (MEM_WB_regWrite && reg_match(MEM_WB_rd, IF_ID_rs1))
                      ? MEM_WB_data : IF_ID_rs1_data;
      ex_d.rs2_data = (MEM_WB_regWrite && reg_match(MEM_WB_rd, IF_ID_rs2))
                      ? MEM_WB_data : IF_ID_rs2_data;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_event && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (EX_flush && (flush_cnt_q != '1))    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign ID_EX_pc       = ex_q.pc;
  assign ID_EX_rs1_data = ex_q.rs1_data;
  assign ID_EX_rs2_data = ex_q.rs2_data;
  assign ID_EX_imm      = ex_q.imm;
  assign ID_EX_rs1      = ex_q.rs1;
  assign ID_EX_rs2      = ex_q.rs2;
  assign ID_EX_rd       = ex_q.rd;
  assign ID_EX_ctrl     = ex_q.ctrl;
  assign ID_EX_valid    = ex_q.valid;
  assign stall_cnt      = stall_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/flush/bypass/reset
// scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_id_ex_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 6;
  localparam int CMAX  = (1 << CNT_W) - 1;

  localparam logic [7:0] CTRL_LW  = 8'b1101_1000; // regWrite memRead memToReg aluSrc, add
  localparam logic [7:0] CTRL_ADD = 8'b1000_0010; // regWrite, R-type

  logic              clk = 1'b0;
  logic              rst_n;
  logic [XLEN-1:0]   IF_ID_pc, IF_ID_rs1_data, IF_ID_rs2_data, IF_ID_imm;
  logic [4:0]        IF_ID_rs1, IF_ID_rs2, IF_ID_rd;
  logic              IF_ID_use_rs1, IF_ID_use_rs2, IF_ID_valid;
  logic [7:0]        IF_ID_ctrl;
  logic              MEM_WB_regWrite;
  logic [4:0]        MEM_WB_rd;
  logic [XLEN-1:0]   MEM_WB_data;
  logic              EX_flush;
  logic [XLEN-1:0]   ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0]        ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic [7:0]        ID_EX_ctrl;
  logic              ID_EX_valid, pc_write, if_id_write;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_pc(IF_ID_pc), .IF_ID_rs1_data(IF_ID_rs1_data),
    .IF_ID_rs2_data(IF_ID_rs2_data), .IF_ID_imm(IF_ID_imm),
    .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2), .IF_ID_rd(IF_ID_rd),
    .IF_ID_use_rs1(IF_ID_use_rs1), .IF_ID_use_rs2(IF_ID_use_rs2),
    .IF_ID_valid(IF_ID_valid), .IF_ID_ctrl(IF_ID_ctrl),
    .MEM_WB_regWrite(MEM_WB_regWrite), .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_data(MEM_WB_data), .EX_flush(EX_flush),
    .ID_EX_pc(ID_EX_pc), .ID_EX_rs1_data(ID_EX_rs1_data),
    .ID_EX_rs2_data(ID_EX_rs2_data), .ID_EX_imm(ID_EX_imm),
    .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
    .ID_EX_ctrl(ID_EX_ctrl), .ID_EX_valid(ID_EX_valid),
    .pc_write(pc_write), .if_id_write(if_id_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model of what EX should hold.
  logic [XLEN-1:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]      m_rs1, m_rs2, m_rd;
  logic [7:0]      m_ctrl;
  logic            m_valid;
  int              m_stall, m_flush;
  logic            m_hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_pc = '0; m_rs1d = '0; m_rs2d = '0; m_imm = '0;
    m_rs1 = '0; m_rs2 = '0; m_rd = '0; m_ctrl = '0; m_valid = 1'b0;
  endtask

  // A load in EX writing a register (not x0) that ID really reads.
  function automatic logic model_hazard();
    logic reads_it;
    reads_it = (IF_ID_use_rs1 && IF_ID_rs1 == m_rd) || (IF_ID_use_rs2 && IF_ID_rs2 == m_rd);
    return m_valid && m_ctrl[6] && m_rd != 0 && IF_ID_valid && reads_it;
  endfunction

  function automatic logic [XLEN-1:0] operand(input logic [4:0] rs, input logic [XLEN-1:0] rf);
    if (MEM_WB_regWrite && MEM_WB_rd != 0 && MEM_WB_rd == rs) return MEM_WB_data;
    return rf;
  endfunction

  task automatic check_regs(input string tag);
    chk({tag, ".pc"},       ID_EX_pc,       m_pc);
    chk({tag, ".rs1_data"}, ID_EX_rs1_data, m_rs1d);
    chk({tag, ".rs2_data"}, ID_EX_rs2_data, m_rs2d);
    chk({tag, ".imm"},      ID_EX_imm,      m_imm);
    chk({tag, ".rs1"},      ID_EX_rs1,      m_rs1);
    chk({tag, ".rs2"},      ID_EX_rs2,      m_rs2);
    chk({tag, ".rd"},       ID_EX_rd,       m_rd);
    chk({tag, ".ctrl"},     ID_EX_ctrl,     m_ctrl);
    chk({tag, ".valid"},    ID_EX_valid,    m_valid);
    chk({tag, ".stall_cnt"}, stall_cnt, m_stall);
    chk({tag, ".flush_cnt"}, flush_cnt, m_flush);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick(input string tag);
    logic hz;
    #1;
    hz = model_hazard();
    m_hold = hz && !EX_flush;
    chk({tag, ".pc_write"},    pc_write,    !m_hold);
    chk({tag, ".if_id_write"}, if_id_write, !m_hold);
    if (EX_flush) begin
      model_clear();
      if (m_flush < CMAX) m_flush++;
    end else if (hz) begin
      model_clear();
      if (m_stall < CMAX) m_stall++;
    end else begin
      m_pc = IF_ID_pc; m_imm = IF_ID_imm;
      m_rs1 = IF_ID_rs1; m_rs2 = IF_ID_rs2; m_rd = IF_ID_rd;
      m_rs1d = operand(IF_ID_rs1, IF_ID_rs1_data);
      m_rs2d = operand(IF_ID_rs2, IF_ID_rs2_data);
      m_valid = IF_ID_valid;
      m_ctrl = IF_ID_valid ? IF_ID_ctrl : 8'h00;
    end
    @(posedge clk);
    #1;
    check_regs(tag);
    @(negedge clk);
  endtask

  task automatic set_id(input logic [7:0] ctrl, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    IF_ID_pc = $urandom; IF_ID_imm = $urandom;
    IF_ID_rs1_data = $urandom; IF_ID_rs2_data = $urandom;
    IF_ID_ctrl = ctrl; IF_ID_rd = rd; IF_ID_valid = 1'b1;
    IF_ID_rs1 = rs1; IF_ID_use_rs1 = u1;
    IF_ID_rs2 = rs2; IF_ID_use_rs2 = u2;
  endtask

  task automatic rand_id();
    set_id(($urandom_range(0, 2) == 0) ? CTRL_LW : 8'($urandom),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
           5'($urandom_range(0, 7)), 1'($urandom));
    IF_ID_valid = ($urandom_range(0, 7) != 0);
  endtask

  initial begin
    rst_n = 1'b0;
    EX_flush = 1'b0;
    MEM_WB_regWrite = 1'b0; MEM_WB_rd = '0; MEM_WB_data = '0;
    set_id(8'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    IF_ID_valid = 1'b0;
    model_clear();
    m_stall = 0; m_flush = 0; m_hold = 1'b0;

    // Reset state
    @(negedge clk);
    #1;
    check_regs("reset");
    chk("reset.pc_write", pc_write, 1'b1);
    rst_n = 1'b1;

    // First edge after reset loads normally
    rand_id();
    IF_ID_valid = 1'b1;
    tick("first_load");

    // Load-use on rs1: one bubble, then the add issues
    set_id(CTRL_LW, 5'd5, 5'd1, 1'b1, 5'd2, 1'b0);
    tick("lu.lw");
    set_id(CTRL_ADD, 5'd6, 5'd5, 1'b1, 5'd3, 1'b1);
    tick("lu.stall");
    chk("lu.bubble_ctrl", ID_EX_ctrl, 8'h00);
    chk("lu.stall_cnt_one", stall_cnt, 1);
    tick("lu.add_issue");
    chk("lu.add_ctrl", ID_EX_ctrl, CTRL_ADD);

    // Load to x0 never stalls
    set_id(CTRL_LW, 5'd0, 5'd1, 1'b1, 5'd2, 1'b0);
    tick("x0.lw");
    set_id(CTRL_ADD, 5'd6, 5'd0, 1'b1, 5'd3, 1'b1);
    tick("x0.add");
    chk("x0.add_valid", ID_EX_valid, 1'b1);

    // Load-use together with flush: flush wins, no hold
    set_id(CTRL_LW, 5'd5, 5'd1, 1'b1, 5'd2, 1'b0);
    tick("lf.lw");
    set_id(CTRL_ADD, 5'd6, 5'd5, 1'b1, 5'd3, 1'b1);
    EX_flush = 1'b1;
    tick("lf.flush");
    EX_flush = 1'b0;
    chk("lf.flush_cnt_one", flush_cnt, 1);
    chk("lf.stall_cnt_unchanged", stall_cnt, 1);

    // Writeback bypass on rs2
    set_id(CTRL_ADD, 5'd8, 5'd1, 1'b1, 5'd7, 1'b1);
    IF_ID_rs2_data = 32'h0;
    MEM_WB_regWrite = 1'b1; MEM_WB_rd = 5'd7; MEM_WB_data = 32'hDEADBEEF;
    tick("bypass");
    chk("bypass.rs2_data", ID_EX_rs2_data, 32'hDEADBEEF);
    MEM_WB_regWrite = 1'b0;

    // Randomized traffic; IF/ID holds its instruction while stalled
    for (int i = 0; i < 300; i++) begin
      if (!m_hold) rand_id();
      EX_flush = ($urandom_range(0, 9) == 0);
      MEM_WB_regWrite = 1'($urandom);
      MEM_WB_rd = 5'($urandom_range(0, 7));
      MEM_WB_data = $urandom;
      tick("rand");
    end
    EX_flush = 1'b0;
    MEM_WB_regWrite = 1'b0;

    // Stall counter saturation: reach all-ones, then two more stalls
    for (int i = 0; i < 2 * CMAX + 8 && m_stall < CMAX; i++) begin
      set_id(CTRL_LW, 5'd3, 5'd1, 1'b0, 5'd2, 1'b0);
      tick("sat.lw");
      set_id(CTRL_ADD, 5'd4, 5'd3, 1'b1, 5'd2, 1'b0);
      tick("sat.stall");
      tick("sat.issue");
    end
    chk("sat.reached_max", stall_cnt, CMAX);
    for (int i = 0; i < 2; i++) begin
      set_id(CTRL_LW, 5'd3, 5'd1, 1'b0, 5'd2, 1'b0);
      tick("sat2.lw");
      set_id(CTRL_ADD, 5'd4, 5'd1, 1'b0, 5'd3, 1'b1);
      tick("sat2.stall");
      chk("sat2.stall_cnt_held", stall_cnt, CMAX);
      tick("sat2.issue");
    end

    // Flush counter saturation
    EX_flush = 1'b1;
    for (int i = 0; i < CMAX + 3; i++) begin
      rand_id();
      tick("fsat");
    end
    EX_flush = 1'b0;
    chk("fsat.flush_cnt_held", flush_cnt, CMAX);

    // Asynchronous reset in the middle of a stall
    set_id(CTRL_LW, 5'd9, 5'd1, 1'b0, 5'd2, 1'b0);
    tick("arst.lw");
    set_id(CTRL_ADD, 5'd4, 5'd9, 1'b1, 5'd2, 1'b0);
    #1;
    chk("arst.pre_pc_write", pc_write, 1'b0);
    #1 rst_n = 1'b0;
    model_clear();
    m_stall = 0; m_flush = 0;
    #1;
    check_regs("arst");
    chk("arst.pc_write", pc_write, 1'b1);
    chk("arst.if_id_write", if_id_write, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    tick("arst.first_load");
    chk("arst.add_loaded", ID_EX_ctrl, CTRL_ADD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
